// File: rtl/gst_dmasnd_seq.sv
// STE DMA sound frame sequencer: CPU frame registers plus a slot-driven word
// fetch engine that feeds the shifter audio FIFO and flags frame end.
module gst_dmasnd_seq #(
    parameter int RAM_LAT  = 2,
    parameter int LOAD_LEN = 4
) (
    input  logic        clk32,
    input  logic        res,
    input  logic        CS,
    input  logic [4:0]  A,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    input  logic        RW,
    input  logic        SLOT,
    input  logic        SREQ,
    output logic [22:0] ADDR,
    output logic        SLOAD_N,
    output logic        SACTIVE,
    output logic        SINT
);

    // state | meaning
    // IDLE  | waiting for a usable SLOT (play, SREQ, frame not exhausted)
    // ADR   | ADDR driven, waiting out the RAM read latency
    // LOAD  | SLOAD_N held low while the shifter takes the word
    // NEXT  | advance cnt, detect frame end, reload or stop
    typedef enum logic [1:0] {IDLE, ADR, LOAD, NEXT} state_t;

    localparam logic [7:0] LAT_M1  = 8'(RAM_LAT - 1);
    localparam logic [7:0] LOAD_M1 = 8'(LOAD_LEN - 1);

    state_t      state;
    logic [7:0]  tmr;
    logic        play, loop;
    logic [22:0] start_w, end_w, cnt, endl, cnt_inc, addr;
    logic        sload_n, sint;
    logic        wr_en;
    logic [7:0]  rd_byte;
    logic        unused_din;

    assign cnt_inc    = cnt + 23'd1;
    assign wr_en      = CS && !RW;
    assign unused_din = ^DIN[15:8];

    always_ff @(posedge clk32 or posedge res) begin
        if (res) begin
            state   <= IDLE;
            tmr     <= 8'd0;
            play    <= 1'b0;
            loop    <= 1'b0;
            start_w <= 23'd0;
            end_w   <= 23'd0;
            cnt     <= 23'd0;
            endl    <= 23'd0;
            addr    <= 23'd0;
            sload_n <= 1'b1;
            sint    <= 1'b0;
        end else begin
            sint <= 1'b0;
            case (state)
                IDLE: begin
                    if (SLOT && SREQ && play) begin
                        if (cnt == endl) begin
                            // empty frame: signal end without touching the bus
                            sint <= 1'b1;
                            if (loop) begin
                                cnt  <= start_w;
                                endl <= end_w;
                            end else begin
                                play <= 1'b0;
                            end
                        end else begin
                            addr <= cnt;
                            if (RAM_LAT == 0) begin
                                state   <= LOAD;
                                sload_n <= 1'b0;
                                tmr     <= LOAD_M1;
                            end else begin
                                state <= ADR;
                                tmr   <= LAT_M1;
                            end
                        end
                    end
                end
                ADR: begin
                    if (tmr == 8'd0) begin
                        state   <= LOAD;
                        sload_n <= 1'b0;
                        tmr     <= LOAD_M1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                LOAD: begin
                    if (tmr == 8'd0) begin
                        state   <= NEXT;
                        sload_n <= 1'b1;
                        // pulse is lined up with the NEXT cycle that hits the end
                        sint    <= (cnt_inc == endl);
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                NEXT: begin
                    state <= IDLE;
                    if (cnt_inc == endl && loop) begin
                        cnt  <= start_w;
                        endl <= end_w;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == endl)
                            play <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // CPU write comes last so it overrides a same-cycle frame-end stop
            if (wr_en) begin
                case (A)
                    5'd0: begin
                        play <= DIN[0];
                        loop <= DIN[1];
                        if (DIN[0] && !play) begin
                            cnt  <= start_w;
                            endl <= end_w;
                        end
                    end
                    5'd1: start_w[22:15] <= DIN[7:0];
                    5'd2: start_w[14:7]  <= DIN[7:0];
                    5'd3: start_w[6:0]   <= DIN[7:1];
                    5'd7: end_w[22:15]   <= DIN[7:0];
                    5'd8: end_w[14:7]    <= DIN[7:0];
                    5'd9: end_w[6:0]     <= DIN[7:1];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (A)
            5'd0: rd_byte = {6'd0, loop, play};
            5'd1: rd_byte = start_w[22:15];
            5'd2: rd_byte = start_w[14:7];
            5'd3: rd_byte = {start_w[6:0], 1'b0};
            5'd4: rd_byte = cnt[22:15];
            5'd5: rd_byte = cnt[14:7];
            5'd6: rd_byte = {cnt[6:0], 1'b0};
            5'd7: rd_byte = end_w[22:15];
            5'd8: rd_byte = end_w[14:7];
            5'd9: rd_byte = {end_w[6:0], 1'b0};
            default: rd_byte = 8'h00;
        endcase
    end

    assign DOUT    = (CS && RW) ? {8'h00, rd_byte} : 16'h0000;
    assign ADDR    = addr;
    assign SLOAD_N = sload_n;
    assign SACTIVE = play;
    assign SINT    = sint;

endmodule

// File: tb/tb_gst_dmasnd_seq.sv
// Directed bench for gst_dmasnd_seq: fetch timing, loop, back-pressure,
// mid-fetch stop, empty frame, register readback and async reset.
`timescale 1ns/1ps
module tb_gst_dmasnd_seq;
    logic        clk32 = 1'b0;
    logic        res = 1'b1;
    logic        CS = 1'b0;
    logic [4:0]  A = 5'd0;
    logic [15:0] DIN = 16'h0000;
    logic [15:0] DOUT;
    logic        RW = 1'b1;
    logic        SLOT = 1'b0;
    logic        SREQ = 1'b0;
    logic [22:0] ADDR;
    logic        SLOAD_N;
    logic        SACTIVE;
    logic        SINT;

    int vecs = 0;
    int errs = 0;

    gst_dmasnd_seq #(.RAM_LAT(2), .LOAD_LEN(4)) dut (
        .clk32(clk32), .res(res), .CS(CS), .A(A), .DIN(DIN), .DOUT(DOUT),
        .RW(RW), .SLOT(SLOT), .SREQ(SREQ), .ADDR(ADDR), .SLOAD_N(SLOAD_N),
        .SACTIVE(SACTIVE), .SINT(SINT)
    );

    always #10 clk32 = ~clk32;

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        CS = 1'b1; RW = 1'b0; A = a; DIN = {8'hA5, d};
        tick();
        CS = 1'b0; RW = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [15:0] exp);
        CS = 1'b1; RW = 1'b1; A = a;
        #1;
        check(tag, {16'h0, DOUT}, {16'h0, exp});
        CS = 1'b0;
    endtask

    // One full fetch starting on a SLOT at the minimum 8-cycle period.
    task automatic fetch(input string tag, input logic [22:0] exp_addr, input logic exp_sint);
        SLOT = 1'b1;
        tick();
        SLOT = 1'b0;
        check({tag, " addr"}, {9'h0, ADDR}, {9'h0, exp_addr});
        check({tag, " pre"}, {31'h0, SLOAD_N}, 32'd1);
        tick();
        check({tag, " lat"}, {31'h0, SLOAD_N}, 32'd1);
        tick();
        check({tag, " fall"}, {31'h0, SLOAD_N}, 32'd0);
        repeat (3) tick();
        check({tag, " hold"}, {31'h0, SLOAD_N}, 32'd0);
        tick();
        check({tag, " rise"}, {31'h0, SLOAD_N}, 32'd1);
        check({tag, " sint"}, {31'h0, SINT}, {31'h0, exp_sint});
        tick();
        check({tag, " sint_end"}, {31'h0, SINT}, 32'd0);
    endtask

    task automatic no_fetch(input string tag);
        int lows;
        lows = 0;
        SLOT = 1'b1;
        tick();
        SLOT = 1'b0;
        repeat (8) begin
            tick();
            if (!SLOAD_N) lows++;
        end
        check({tag, " no_load"}, lows, 32'd0);
    endtask

    initial begin
        // reset state
        SREQ = 1'b1;
        repeat (2) tick();
        check("rst addr", {9'h0, ADDR}, 32'd0);
        check("rst sload", {31'h0, SLOAD_N}, 32'd1);
        check("rst sint", {31'h0, SINT}, 32'd0);
        check("rst sactive", {31'h0, SACTIVE}, 32'd0);
        rd("rst ctrl", 5'd0, 16'h0000);
        res = 1'b0;
        tick();

        // basic fetch: 0x010000..0x010006
        wr(5'd1, 8'h01); wr(5'd2, 8'h00); wr(5'd3, 8'h00);
        wr(5'd7, 8'h01); wr(5'd8, 8'h00); wr(5'd9, 8'h06);
        wr(5'd0, 8'h01);
        check("play sactive", {31'h0, SACTIVE}, 32'd1);
        rd("cnt hi", 5'd4, 16'h0001);
        rd("cnt lo", 5'd6, 16'h0000);
        fetch("f0", 23'h8000, 1'b0);
        fetch("f1", 23'h8001, 1'b0);
        fetch("f2", 23'h8002, 1'b1);
        check("end sactive", {31'h0, SACTIVE}, 32'd0);
        rd("end cnt lo", 5'd6, 16'h0006);
        no_fetch("after end");

        // loop: 9 fetches, SINT on every third
        wr(5'd0, 8'h03);
        for (int i = 0; i < 9; i++)
            fetch($sformatf("loop%0d", i), 23'h8000 + 23'(i % 3), (i % 3) == 2);
        check("loop sactive", {31'h0, SACTIVE}, 32'd1);
        rd("loop cnt lo", 5'd6, 16'h0000);

        // back-pressure
        SREQ = 1'b0;
        no_fetch("bp0");
        no_fetch("bp1");
        rd("bp cnt lo", 5'd6, 16'h0000);
        rd("bp cnt mid", 5'd5, 16'h0000);
        SREQ = 1'b1;
        fetch("bp resume", 23'h8000, 1'b0);
        rd("bp cnt after", 5'd6, 16'h0002);

        // stop during LOAD
        SLOT = 1'b1;
        tick();
        SLOT = 1'b0;
        check("stop addr", {9'h0, ADDR}, 32'h8001);
        tick();
        tick();
        check("stop fall", {31'h0, SLOAD_N}, 32'd0);
        wr(5'd0, 8'h00);
        check("stop sactive", {31'h0, SACTIVE}, 32'd0);
        check("stop low1", {31'h0, SLOAD_N}, 32'd0);
        tick();
        tick();
        check("stop low3", {31'h0, SLOAD_N}, 32'd0);
        tick();
        check("stop rise", {31'h0, SLOAD_N}, 32'd1);
        check("stop sint", {31'h0, SINT}, 32'd0);
        tick();
        rd("stop cnt lo", 5'd6, 16'h0004);
        no_fetch("stop idle");

        // degenerate frame start == end
        wr(5'd1, 8'h02); wr(5'd2, 8'h00); wr(5'd3, 8'h00);
        wr(5'd7, 8'h02); wr(5'd8, 8'h00); wr(5'd9, 8'h00);
        wr(5'd0, 8'h01);
        SLOT = 1'b1;
        tick();
        SLOT = 1'b0;
        check("degen sint", {31'h0, SINT}, 32'd1);
        check("degen sload", {31'h0, SLOAD_N}, 32'd1);
        check("degen sactive", {31'h0, SACTIVE}, 32'd0);
        tick();
        check("degen sint_end", {31'h0, SINT}, 32'd0);
        check("degen sload2", {31'h0, SLOAD_N}, 32'd1);

        // register readback
        wr(5'd3, 8'h13);
        rd("start lo", 5'd3, 16'h0012);
        wr(5'd9, 8'hFF);
        rd("end lo", 5'd9, 16'h00FE);
        rd("start hi", 5'd1, 16'h0002);
        wr(5'd12, 8'h55);
        rd("unmapped", 5'd12, 16'h0000);
        CS = 1'b1; RW = 1'b0; A = 5'd1;
        #1;
        check("dout on write", {16'h0, DOUT}, 32'd0);
        CS = 1'b0; RW = 1'b1;

        // async reset mid-fetch
        wr(5'd0, 8'h01);
        SLOT = 1'b1;
        tick();
        SLOT = 1'b0;
        check("rfetch addr", {9'h0, ADDR}, 32'h10009);
        tick();
        tick();
        check("rfetch fall", {31'h0, SLOAD_N}, 32'd0);
        res = 1'b1;
        #1;
        check("async sload", {31'h0, SLOAD_N}, 32'd1);
        check("async addr", {9'h0, ADDR}, 32'd0);
        check("async sactive", {31'h0, SACTIVE}, 32'd0);
        for (int a = 0; a < 10; a++)
            rd($sformatf("rst reg%0d", a), 5'(a), 16'h0000);
        tick();
        res = 1'b0;
        no_fetch("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
